// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the init sequencer state enum, default sizing constants and
// the address qualification helper used by both write and read paths.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  // An address is usable when it lies inside the array and is not the
  // hard-wired zero entry (when that entry is enabled).
  function automatic logic addr_valid(input int unsigned addr,
                                      input int unsigned depth,
                                      input logic        zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clearing sequencer for the register file.
// Walks a counter over every entry once after reset, asserting clr_en
// with clr_addr, then parks in RF_RUN and raises init_done.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_done
);

  rf_state_e         state;
  rf_state_e         stateNext;
  logic [ADDR_W-1:0] clearCount;
  logic [ADDR_W-1:0] clearCountNext;

  // State and clear counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RF_CLEAR;
      clearCount <= '0;
    end else begin
      state      <= stateNext;
      clearCount <= clearCountNext;
    end
  end

  // Advance the counter while clearing; leave CLEAR after the last entry.
  always_comb begin
    stateNext      = state;
    clearCountNext = clearCount;
    clr_en         = 1'b0;
    init_done      = 1'b0;
    case (state)
      RF_CLEAR: begin
        clr_en = 1'b1;
        if (clearCount == ADDR_W'(DEPTH - 1)) begin
          stateNext = RF_RUN;
        end else begin
          clearCountNext = clearCount + ADDR_W'(1);
        end
      end
      RF_RUN: begin
        init_done = 1'b1;
      end
    endcase
  end

  assign clr_addr = clearCount;

endmodule

// File: rtl/mp_register_file.sv
// Parametrised multi-port register file with registered reads,
// optional zero register and a post-reset clearing sequence.
// Define REGFILE_WR_BYPASS_EN for write-first reads (same-cycle write
// data forwarded to reads); otherwise reads return the old contents.
module mp_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     wr_conflict,
  output logic                     init_done
);

  localparam logic ZeroRegEn = (ZERO_REG != 0);

  logic              clrEn;
  logic [ADDR_W-1:0] clrAddr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_WR-1:0] wrAccept;
  logic [DATA_W-1:0] readValue [NUM_RD];
  logic              conflictNext;

  regfile_init_seq #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) initSeq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_en   (clrEn),
    .clr_addr (clrAddr),
    .init_done(init_done)
  );

  // A write port takes effect only after clearing and on a usable address.
  always_comb begin
    wrAccept = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wrAccept[w] = init_done && wr_en[w] &&
                    addr_valid(32'(wr_addr[w*ADDR_W +: ADDR_W]), DEPTH, ZeroRegEn);
    end
  end

  // Two accepted writers aimed at the same entry is a conflict.
  always_comb begin
    conflictNext = 1'b0;
    if (NUM_WR == 2) begin
      conflictNext = wrAccept[0] && wrAccept[NUM_WR-1] &&
                     (wr_addr[0 +: ADDR_W] == wr_addr[(NUM_WR-1)*ADDR_W +: ADDR_W]);
    end
  end

  // Array update: clearing has priority, later write ports override earlier ones.
  always_ff @(posedge clk) begin
    if (clrEn) begin
      mem[clrAddr] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wrAccept[w]) begin
          mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Per-port read value, zero for unusable addresses, optionally forwarding writes.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      readValue[p] = '0;
      if (addr_valid(32'(rd_addr[p*ADDR_W +: ADDR_W]), DEPTH, ZeroRegEn)) begin
        readValue[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_WR_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (wrAccept[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])) begin
            readValue[p] = wr_data[w*DATA_W +: DATA_W];
          end
        end
`endif
      end
    end
  end

  // Registered read outputs and the one-cycle conflict pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data     <= '0;
      rd_valid    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflictNext;
      for (int p = 0; p < NUM_RD; p++) begin
        if (init_done && rd_en[p]) begin
          rd_data[p*DATA_W +: DATA_W] <= readValue[p];
          rd_valid[p]                 <= 1'b1;
        end else begin
          rd_valid[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mp_register_file.sv
// Self-checking bench for mp_register_file (default parameters).
// Table of directed vectors, randomized traffic against a reference
// model of the register file, and reset/clear sequences.
module tb_mp_register_file;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_conflict;
  logic        init_done;

  int testsRun  = 0;
  int failCount = 0;

  logic [31:0] refMem [32];
  logic [31:0] expRd  [2];

  typedef struct {
    string       name;
    logic [1:0]  wrEn;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  rdEn;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  expValid;
    logic [31:0] expD0;
    logic [31:0] expD1;
    logic        expConf;
  } vec_t;

  vec_t vecs [14];

  mp_register_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_conflict(wr_conflict),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] wrEn, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [1:0] rdEn, input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en   = wrEn;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rd_en   = rdEn;
    rd_addr = {ra1, ra0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 32; i++) refMem[i] = 32'h0;
    expRd[0] = 32'h0;
    expRd[1] = 32'h0;
  endtask

  // Value a read of addr returns given this cycle's write traffic.
  function automatic logic [31:0] modelRead(input logic [4:0] a, input logic [1:0] wrEn,
                                            input logic [4:0] wa0, input logic [31:0] wd0,
                                            input logic [4:0] wa1, input logic [31:0] wd1);
    if (a == 5'd0) return 32'h0;
    if (Bypass && wrEn[1] && wa1 == a) return wd1;
    if (Bypass && wrEn[0] && wa0 == a) return wd0;
    return refMem[a];
  endfunction

  task automatic modelWrite(input logic [1:0] wrEn, input logic [4:0] wa0, input logic [31:0] wd0,
                            input logic [4:0] wa1, input logic [31:0] wd1);
    if (wrEn[0] && wa0 != 5'd0) refMem[wa0] = wd0;
    if (wrEn[1] && wa1 != 5'd0) refMem[wa1] = wd1;
  endtask

  // Reset release and clearing: init_done only after edge 32, no reads until edge 33.
  task automatic runClear(input string tag, input logic [4:0] ra0, input logic [4:0] ra1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      checkOutput($sformatf("%s_initDone_e%0d", tag, k), 32'(init_done), (k == 32) ? 32'h1 : 32'h0);
      checkOutput($sformatf("%s_rdValid_e%0d", tag, k), 32'(rd_valid), 32'h0);
    end
    checkOutput({tag, "_rdDataClear"}, rd_data[31:0], 32'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, ra0, ra1);
    tick();
    checkOutput({tag, "_firstValid"}, 32'(rd_valid), 32'h3);
    checkOutput({tag, "_firstData0"}, rd_data[31:0], 32'h0);
    checkOutput({tag, "_firstData1"}, rd_data[63:32], 32'h0);
    resetModel();
  endtask

  initial begin
    logic [1:0]  wrEn;
    logic [4:0]  wa0, wa1, ra0, ra1;
    logic [31:0] wd0, wd1;
    logic [1:0]  rdEn;
    logic        expConf;

    vecs[0]  = '{"wrP0_5",       2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,    2'b00, 5'd0,  5'd0,  2'b00, 32'h0,        32'h0,    1'b0};
    vecs[1]  = '{"rd5",          2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b11, 5'd5,  5'd0,  2'b11, 32'hDEADBEEF, 32'h0,    1'b0};
    vecs[2]  = '{"wrZero",       2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,    2'b00, 5'd0,  5'd0,  2'b00, 32'hDEADBEEF, 32'h0,    1'b0};
    vecs[3]  = '{"rdZero",       2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b11, 5'd0,  5'd0,  2'b11, 32'h0,        32'h0,    1'b0};
    vecs[4]  = '{"collide9",     2'b11, 5'd9,  32'hAAAA,     5'd9,  32'h5555, 2'b00, 5'd0,  5'd0,  2'b00, 32'h0,        32'h0,    1'b1};
    vecs[5]  = '{"pulseEnd",     2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b00, 5'd0,  5'd0,  2'b00, 32'h0,        32'h0,    1'b0};
    vecs[6]  = '{"rd9",          2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b11, 5'd9,  5'd9,  2'b11, 32'h5555,     32'h5555, 1'b0};
    vecs[7]  = '{"wr3",          2'b10, 5'd0,  32'h0,        5'd3,  32'h11,   2'b00, 5'd0,  5'd0,  2'b00, 32'h5555,     32'h5555, 1'b0};
    vecs[8]  = '{"sameCyc3",     2'b01, 5'd3,  32'h77,       5'd0,  32'h0,    2'b01, 5'd3,  5'd0,  2'b01, Bypass ? 32'h77 : 32'h11, 32'h5555, 1'b0};
    vecs[9]  = '{"rd3After",     2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b01, 5'd3,  5'd0,  2'b01, 32'h77,       32'h5555, 1'b0};
    vecs[10] = '{"dropZeroBoth", 2'b11, 5'd0,  32'h1,        5'd0,  32'h2,    2'b10, 5'd0,  5'd0,  2'b10, 32'h77,       32'h0,    1'b0};
    vecs[11] = '{"collide12Rd",  2'b11, 5'd12, 32'h1,        5'd12, 32'h2,    2'b10, 5'd0,  5'd12, 2'b10, 32'h77,       Bypass ? 32'h2 : 32'h0, 1'b1};
    vecs[12] = '{"rd12",         2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b11, 5'd12, 5'd12, 2'b11, 32'h2,        32'h2,    1'b0};
    vecs[13] = '{"holdOff",      2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b00, 5'd5,  5'd5,  2'b00, 32'h2,        32'h2,    1'b0};

    // Reset values, with junk writes presented throughout clearing.
    rst_n = 1'b0;
    applyStimulus(2'b11, 5'd7, 32'hBAD00007, 5'd31, 32'hBAD0001F, 2'b11, 5'd7, 5'd31);
    #2;
    checkOutput("rst_rdData", rd_data[31:0] | rd_data[63:32], 32'h0);
    checkOutput("rst_rdValid", 32'(rd_valid), 32'h0);
    checkOutput("rst_conflict", 32'(wr_conflict), 32'h0);
    checkOutput("rst_initDone", 32'(init_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    runClear("clr", 5'd7, 5'd31);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].wrEn, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                    vecs[i].rdEn, vecs[i].ra0, vecs[i].ra1);
      tick();
      checkOutput({vecs[i].name, "_valid"}, 32'(rd_valid), 32'(vecs[i].expValid));
      checkOutput({vecs[i].name, "_data0"}, rd_data[31:0], vecs[i].expD0);
      checkOutput({vecs[i].name, "_data1"}, rd_data[63:32], vecs[i].expD1);
      checkOutput({vecs[i].name, "_conflict"}, 32'(wr_conflict), 32'(vecs[i].expConf));
      modelWrite(vecs[i].wrEn, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1);
      expRd[0] = vecs[i].expD0;
      expRd[1] = vecs[i].expD1;
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      wrEn = 2'($urandom_range(0, 3));
      wa0  = 5'($urandom_range(0, 31));
      wa1  = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      wd0  = $urandom;
      wd1  = $urandom;
      rdEn = 2'($urandom_range(0, 3));
      ra0  = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra1  = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
      applyStimulus(wrEn, wa0, wd0, wa1, wd1, rdEn, ra0, ra1);
      if (rdEn[0]) expRd[0] = modelRead(ra0, wrEn, wa0, wd0, wa1, wd1);
      if (rdEn[1]) expRd[1] = modelRead(ra1, wrEn, wa0, wd0, wa1, wd1);
      expConf = (wrEn == 2'b11) && (wa0 == wa1) && (wa0 != 5'd0);
      tick();
      checkOutput($sformatf("rnd%0d_valid", i), 32'(rd_valid), 32'(rdEn));
      checkOutput($sformatf("rnd%0d_data0", i), rd_data[31:0], expRd[0]);
      checkOutput($sformatf("rnd%0d_data1", i), rd_data[63:32], expRd[1]);
      checkOutput($sformatf("rnd%0d_conflict", i), 32'(wr_conflict), 32'(expConf));
      modelWrite(wrEn, wa0, wd0, wa1, wd1);
    end

    // Mid-run reset: pending conflict and valid read data must vanish at once.
    applyStimulus(2'b11, 5'd4, 32'h11, 5'd4, 32'hFF, 2'b00, 5'd0, 5'd0);
    tick();
    checkOutput("pre_conflict", 32'(wr_conflict), 32'h1);
    applyStimulus(2'b11, 5'd6, 32'h1, 5'd6, 32'h2, 2'b01, 5'd4, 5'd0);
    tick();
    checkOutput("pre_rd4", rd_data[31:0], 32'hFF);
    checkOutput("pre_valid", 32'(rd_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRst_rdData", rd_data[31:0], 32'h0);
    checkOutput("midRst_rdValid", 32'(rd_valid), 32'h0);
    checkOutput("midRst_conflict", 32'(wr_conflict), 32'h0);
    checkOutput("midRst_initDone", 32'(init_done), 32'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd6);
    @(negedge clk);
    rst_n = 1'b1;
    runClear("reclr", 5'd4, 5'd6);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/mp_register_file.md
# mp_register_file

Parametrised multi-port register file, successor to the single-write, two-read, 32x32 processor register file. It provides NUM_RD registered read ports, NUM_WR write ports, an optional hard-wired zero register and a post-reset clearing sequencer with an init_done flag. It sits in the decode stage of the pipelined datapath; the writeback stage drives its write ports.

## Interface
Parameters:
- DATA_W, 32, bits per register
- DEPTH, 32, number of registers (≥2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- NUM_RD, 2, read ports (1–4)
- NUM_WR, 2, write ports (1–2)
- ZERO_REG, 1, when 1, entry 0 reads as 0 and ignores writes

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  rd_data of port p is valid this cycle
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- wr_conflict  out  1  registered pulse: two enabled write ports targeted the same valid address
- init_done  out  1  high once the array has been cleared

## Operation
- Reset values: rd_data=0, rd_valid=0, wr_conflict=0, init_done=0, state=CLEAR, clear counter=0.
- States:
  - CLEAR: each posedge writes 0 to entry[counter] and increments the counter. At counter==DEPTH-1 the FSM moves to RUN and init_done goes to 1.
  - RUN: terminal state.
- During CLEAR, wr_en is ignored, rd_valid stays 0 and rd_data stays 0.
- Write in RUN: entry[wr_addr[w]] ← wr_data[w] on posedge.
  - Dropped if the address is ≥ DEPTH.
  - Dropped if ZERO_REG=1 and the address is 0.
- Write collision: if both ports hit the same address, the higher-index port wins. wr_conflict=1 on the next cycle, for one cycle. Dropped writes never cause a conflict.
- Read in RUN: on posedge with rd_en[p]=1, rd_data[p] ← entry[rd_addr[p]] and rd_valid[p] ← 1.
  - Returns 0 if the address is ≥ DEPTH, or if ZERO_REG=1 and the address is 0.
- rd_en[p]=0: rd_valid[p] ← 0 and rd_data[p] holds its last value.
- Any number of read ports may use the same address in the same cycle.
- Reset asserted mid-operation: immediate return to reset values and CLEAR. Array contents are then undefined until clearing completes.

## Timing
- Read latency 1 cycle: address in cycle n, data and valid in cycle n+1.
- Write visible to a normal read issued in cycle n+1 or later.
- Same-cycle read/write to the same address: see Configuration.
- Clearing: reset released before edge 1. Edges 1..DEPTH clear entries 0..DEPTH-1. init_done=1 after edge DEPTH. The first accepted read or write is in the cycle after that edge.
- rst_n is used asynchronously on assertion. Release is assumed already synchronised to clk upstream.

## Configuration
- REGFILE_WR_BYPASS_EN defined: write-first behaviour. A read in cycle n to an address being written in cycle n returns the new wr_data in n+1. With two colliding writers, it returns the winning port's data. Zero-register and out-of-range rules still apply.
- REGFILE_WR_BYPASS_EN undefined: read-first behaviour. The same read returns the old array value. Software or the pipeline forwarding unit resolves the hazard.

## Structure
- Package regfile_pkg holds:
  - state enum rf_state_e {RF_CLEAR, RF_RUN}
  - default parameter constants RF_DATA_W=32, RF_DEPTH=32
  - helper function addr_valid(addr, depth, zero_reg)
- Sub-module regfile_init_seq contains the CLEAR/RUN FSM and clear counter. It outputs clr_en, clr_addr and init_done.
- Array, read ports, bypass muxes and conflict detection live in the top module.

## Test plan
- Reset release, DEPTH=32: init_done=0 for edges 1–31 and =1 after edge 32. rd_en held high throughout keeps rd_valid=0 until the cycle after init_done.
- Write port 0: addr 5, data 0xDEADBEEF. Read addr 5 next cycle → rd_data=0xDEADBEEF, rd_valid=1 one cycle later.
- ZERO_REG=1: write 0x1234 to addr 0, then read addr 0 on both ports → 0 on both, wr_conflict=0.
- Both write ports hit addr 9 with 0xAAAA (port 0) and 0x5555 (port 1) → wr_conflict pulses for 1 cycle. A later read returns 0x5555.
- Same-cycle write 0x77 / read of addr 3 holding 0x11:
  - with REGFILE_WR_BYPASS_EN → 0x77
  - without → 0x11, and 0x77 on the following read.
- rst_n pulsed low mid-RUN (addr 4 = 0xFF) → outputs reset immediately, init_done=0. After 32 edges, a read of addr 4 returns 0.
